// File: rtl/onehot_sel_pkg.sv
// Shared widths, reset value and one-hot helper for the piece selector.
package onehot_sel_pkg;

    localparam int SEL_W = 8;
    localparam int IDX_W = 3;
    localparam logic [SEL_W-1:0] SEL_RESET = 8'b00000001;

    // OR-reduction rather than a priority search: the input is always one-hot.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [SEL_W-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, stability counter and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce
    import onehot_sel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20'd1000000,
    parameter int          CNT_W           = 20
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    output logic o_Level,
    output logic o_Press
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic             deb_d_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            deb_d_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= i_Raw;
            sync2_reg <= sync1_reg;
            deb_d_reg <= deb_reg;
            // Any sample agreeing with the accepted level restarts the run.
            if (sync2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_reg <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign o_Level = deb_reg;
    assign o_Press = deb_reg & ~deb_d_reg;

endmodule

// File: rtl/onehot_piece_selector.sv
// Next/prev buttons to an 8-bit one-hot piece selection with wrap-around.
// Define ONEHOT_SEL_AUTO_REPEAT_EN to add hold-to-repeat stepping.
module onehot_piece_selector
    import onehot_sel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20'd1000000,
    parameter int          CNT_W           = 20,
    parameter int          REPEAT_DELAY    = 25000000,
    parameter int          REPEAT_PERIOD   = 10000000
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Btn_Next,
    input  logic             i_Btn_Prev,
    input  logic             i_Lock,
    output logic [SEL_W-1:0] o_Sel_OneHot,
    output logic [IDX_W-1:0] o_Sel_Index,
    output logic             o_Sel_Changed
);

    localparam int NBTN = 2;

    // Index 0 is "next", index 1 is "prev".
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] step;

    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] sel_next;
    logic [IDX_W-1:0] idx_reg;
    logic             changed_reg;
    logic             move;

    assign raw = {i_Btn_Prev, i_Btn_Next};

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .i_Clk   (i_Clk),
                .i_Rst_n (i_Rst_n),
                .i_Raw   (raw[gi]),
                .o_Level (level[gi]),
                .o_Press (press[gi])
            );
        end
    endgenerate

`ifdef ONEHOT_SEL_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_rep
            logic [REP_W-1:0] rep_cnt_reg;
            logic             rep_fire;

            assign rep_fire = level[gi] & (rep_cnt_reg == REP_W'(REPEAT_DELAY - 1));

            // After each repeat the counter reloads so the next one lands
            // REPEAT_PERIOD clocks later.
            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    rep_cnt_reg <= '0;
                end else if (!level[gi] || press[gi] || press[NBTN-1-gi]) begin
                    rep_cnt_reg <= '0;
                end else if (rep_fire) begin
                    rep_cnt_reg <= REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    rep_cnt_reg <= rep_cnt_reg + 1'b1;
                end
            end

            assign step[gi] = press[gi] | rep_fire;
        end
    endgenerate
`else
    assign step = press & level;
`endif

    assign move = ~i_Lock & (step[0] ^ step[1]);

    always_comb begin
        sel_next = sel_reg;
        if (move) begin
            if (step[0]) begin
                sel_next = {sel_reg[SEL_W-2:0], sel_reg[SEL_W-1]};
            end else begin
                sel_next = {sel_reg[0], sel_reg[SEL_W-1:1]};
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sel_reg     <= SEL_RESET;
            idx_reg     <= '0;
            changed_reg <= 1'b0;
        end else begin
            sel_reg     <= sel_next;
            idx_reg     <= onehot_to_idx(sel_next);
            changed_reg <= move;
        end
    end

    assign o_Sel_OneHot  = sel_reg;
    assign o_Sel_Index   = idx_reg;
    assign o_Sel_Changed = changed_reg;

endmodule

// File: doc/onehot_piece_selector.md
Name: onehot_piece_selector

Overview:
- Front-end stage for the one-hot-to-7-segment display decoder.
- Turns two raw push-buttons (next/prev) into an 8-bit one-hot selection of the active tangram piece/slot.
- Output feeds the decoder's 8-bit one-hot input directly; the VGA logic may also use it.
- Performs synchronisation, debounce, edge detection and wrap-around rotation.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000, consecutive stable clocks before a button level is accepted (min 2).
- CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES.
- REPEAT_DELAY, 25000000, clocks a held button waits before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 10000000, clocks between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Btn_Next  in  1  raw, asynchronous, active-high button
- i_Btn_Prev  in  1  raw, asynchronous, active-high button
- i_Lock  in  1  synchronous; when 1, accepted presses are discarded
- o_Sel_OneHot  out  8  current selection, always exactly one bit set
- o_Sel_Index  out  3  binary index of the set bit (bit0 -> 0)
- o_Sel_Changed  out  1  one-cycle pulse in the cycle after o_Sel_OneHot updates

Behaviour:
- Reset (async assert, sync release by the system) forces:
  - o_Sel_OneHot = 8'b00000001, o_Sel_Index = 0, o_Sel_Changed = 0.
  - All synchronisers, debounced levels, delayed levels and counters to 0.
- Per button:
  - Synchronise through a 2-flop chain.
  - The debounced level deb flips to the synced value on the DEBOUNCE_CYCLES-th consecutive edge at which synced != deb.
  - Any edge with synced == deb clears the counter.
  - press = deb & ~deb_d, where deb_d is deb registered one clock later; press is high for exactly one cycle per accepted rise.
  - Release is debounced identically but generates no event.
- Step rules, applied at the edge where the press pulse is high:
  - next only: rotate left; 8'b10000000 wraps to 8'b00000001.
  - prev only: rotate right; 8'b00000001 wraps to 8'b10000000.
  - next and prev in the same cycle: no change, no o_Sel_Changed.
  - i_Lock = 1 at that edge: press discarded permanently (not queued).
- Latency: raw input high and stable from before edge 1 updates o_Sel_OneHot at edge DEBOUNCE_CYCLES+3.
- o_Sel_Changed is high for the cycle after that edge.
- o_Sel_Index is registered alongside o_Sel_OneHot and is always consistent with it.
- Glitches shorter than DEBOUNCE_CYCLES clocks produce no change.
- Holding a button produces exactly one step (without AUTO_REPEAT_EN).
- Reset mid-debounce or mid-hold: state returns to reset values. A button still held after release of reset must pass a full debounce and then produces one step.

Optional Feature:
- Macro: ONEHOT_SEL_AUTO_REPEAT_EN.
- Defined: while a debounced button stays high, a repeat counter runs.
  - After REPEAT_DELAY clocks past the initial press pulse, one extra step pulse fires, then one every REPEAT_PERIOD clocks until release.
  - Counter clears on release or when the other button is pressed.
  - Repeat pulses obey the same lock and simultaneity rules as press pulses.
- Undefined: no repeat logic is synthesised; REPEAT_* parameters are ignored; one step per press.

Decomposition:
- Package onehot_sel_pkg:
  - SEL_W = 8
  - IDX_W = 3
  - SEL_RESET = 8'b00000001
  - function onehot_to_idx
- Sub-module btn_debounce, instantiated twice:
  - Ports: i_Clk, i_Rst_n, i_Raw, o_Level, o_Press.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Contains the synchroniser, counter and edge detector.
- Auto-repeat logic lives in the top module.

Test Plan (DEBOUNCE_CYCLES = 4; REPEAT_DELAY = 10 and REPEAT_PERIOD = 5 when the macro is on):
- Reset then idle 20 cycles -> o_Sel_OneHot = 8'h01, o_Sel_Index = 0, o_Sel_Changed never high.
- Next held 10 cycles from before edge 1 -> one change at edge 7 to 8'h02, o_Sel_Changed high one cycle. Eight presses total -> sequence 02,04,…,80,01 (wrap).
- Prev from reset -> 8'h80, index 7. Second prev -> 8'h40.
- 3-cycle pulses on next (shorter than debounce) -> no change. Next and prev pressed on the same cycle -> no change, no pulse.
- i_Lock = 1 during a press pulse -> selection unchanged; lock cleared while still held -> still unchanged.
- Macro on, next held 40 cycles -> steps at edge 7 then every 5 cycles from edge 17: 02,04,08,10,20,40,80.
